mc_control_unit: RTL
====================

// Module: mc_control_unit
// PURPOSE
//  Multi-cycle sequencer for the processor datapath. Latches each fetched instruction and steps FETCH→DECODE→EXEC→(MEM|MD_WAIT)→WB.
//  Drives the datapath control strobes (en_pc, mux selects, branch/jump flags) and the regfile/dmem write enables from its state.
//  Also runs the start/ready handshake with the multdiv unit. Sits between imem/dmem/regfile/multdiv and the datapath, inside the processor.
// PARAMETERS
//  DWIDTH      32   instruction/data width
//  MD_TIMEOUT  64   max MD_WAIT cycles before abort (>=2)
//  CNT_W       32   width of retired-instruction counter
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       asynchronous, active-low reset
//  ins             in   DWIDTH  imem q, valid in the cycle after FETCH
//  data_resultRDY  in   1       multdiv result valid (level)
//  data_exception  in   1       multdiv exception, sampled with data_resultRDY
//  en_pc           out  1       PC update strobe (1 cycle per instruction)
//  en_writeReg     out  1       regfile write strobe
//  en_dmem_wr      out  1       dmem write strobe
//  sel_alu_dataB   out  1       1=sign-ext imm, 0=regB
//  sel_writeReg    out  1       1=dmem q, 0=ALU/writeback
//  ctrl_sw, ctrl_addi, is_alu, ctrl_Bne, ctrl_Blt, ctrl_ji, ctrl_jal, ctrl_jr  out 1 each  datapath decode flags
//  ctrl_MULT       out  1       multdiv start, mult
//  ctrl_DIV        out  1       multdiv start, div
//  md_exc_wb       out  1       force writeback of 1 to $30 (multdiv exception)
//  md_timeout_err  out  1       sticky: multdiv timed out
//  busy            out  1       0 only in FETCH
//  retired_cnt     out  CNT_W   count of en_pc pulses
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH; all outputs 0; instruction register IR=0; counters=0.
//  Decode (from IR): opcode=IR[31:27], aluop=IR[6:2].
//   Opcodes: ALU 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000.
//   mult is ALU with aluop 00110; div is ALU with aluop 00111.
//  FETCH: imem read issued. Go to DECODE.
//  DECODE: IR<=ins. Go to EXEC.
//  Decode flags are registered from IR and held constant from EXEC through the instruction's final state.
//   They are 0 in FETCH/DECODE.
//  EXEC transitions:
//   - ALU (non-md), addi, jal: go to WB.
//   - lw, sw: go to MEM.
//   - mult/div: pulse ctrl_MULT or ctrl_DIV for exactly 1 cycle, then go to MD_WAIT.
//   - j, jr, bne, blt: en_pc=1 this cycle, then go to FETCH (3 cycles total).
//   - Unknown opcode: treated as NOP. en_pc=1, then go to FETCH.
//  MEM:
//   - sw: en_dmem_wr=1, en_pc=1, then go to FETCH (4 cycles).
//   - lw: sel_writeReg=1, then go to WB.
//  MD_WAIT: timer counts from 0.
//   - data_resultRDY=1: go to WB. md_exc_wb<=data_exception.
//   - timer==MD_TIMEOUT-1 with no ready: md_timeout_err<=1, en_pc=1, no register write, go to FETCH.
//   - If ready and timeout land on the same cycle, ready wins.
//  WB: en_writeReg=1 and en_pc=1 for 1 cycle, then go to FETCH.
//   - Latency: ALU/addi/jal 4 cycles; lw 5 cycles; mult/div 4 + wait cycles.
//   - Write to $0 is not suppressed here; the regfile ignores it.
//  en_pc, en_writeReg and en_dmem_wr are each high for at most one cycle per instruction. They are never high in FETCH/DECODE.
//  retired_cnt increments on every en_pc cycle and wraps at 2^CNT_W to 0.
//  md_timeout_err is cleared only by reset.
//  Reset mid-instruction: in-flight writes are dropped; restart at FETCH with retired_cnt=0.
//  data_resultRDY outside MD_WAIT is ignored.
// CONFIGURATION
//  CTRL_MULTDIV_EN defined: full MD_WAIT path as described above.
//  CTRL_MULTDIV_EN undefined: mult/div decode as NOP (en_pc only, no write).
//   In that build ctrl_MULT, ctrl_DIV, md_exc_wb and md_timeout_err are tied to 0, and the MD_WAIT state and timer are removed.
// TESTING
//  1. Release rst after 3 clk; addi $1,$0,5 → en_pc at cycle 4; en_writeReg, sel_alu_dataB and ctrl_addi high in WB; retired_cnt=1.
//  2. lw then sw → lw: sel_writeReg=1 in MEM+WB, write in cycle 5. sw: en_dmem_wr and en_pc high in cycle 4, en_writeReg=0.
//  3. bne, j, jr → each retires in 3 cycles with ctrl_Bne/ctrl_ji/ctrl_jr high in EXEC; en_writeReg stays 0.
//  4. (MULTDIV_EN) mult, RDY after 10 cycles with exception=1 → ctrl_MULT pulses 1 cycle; WB has md_exc_wb=1 and en_writeReg=1.
//  5. (MULTDIV_EN) div with RDY never asserted → en_pc after MD_TIMEOUT=64 wait cycles; md_timeout_err=1 and sticky; no write.
//  6. Assert rst during MEM of sw → en_dmem_wr drops immediately; all outputs 0; state FETCH; retired_cnt=0.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control-unit bus: instruction/multdiv inputs and datapath control outputs.
// master = control unit side, slave = datapath/memories/multdiv side.
interface mc_control_unit_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned CNT_W  = 32
);
    logic [DWIDTH-1:0] ins;
    logic              data_resultRDY;
    logic              data_exception;
    logic              en_pc;
    logic              en_writeReg;
    logic              en_dmem_wr;
    logic              sel_alu_dataB;
    logic              sel_writeReg;
    logic              ctrl_sw;
    logic              ctrl_addi;
    logic              is_alu;
    logic              ctrl_Bne;
    logic              ctrl_Blt;
    logic              ctrl_ji;
    logic              ctrl_jal;
    logic              ctrl_jr;
    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic              md_exc_wb;
    logic              md_timeout_err;
    logic              busy;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        input  ins, data_resultRDY, data_exception,
        output en_pc, en_writeReg, en_dmem_wr, sel_alu_dataB, sel_writeReg,
               ctrl_sw, ctrl_addi, is_alu, ctrl_Bne, ctrl_Blt, ctrl_ji, ctrl_jal, ctrl_jr,
               ctrl_MULT, ctrl_DIV, md_exc_wb, md_timeout_err, busy, retired_cnt
    );

    modport slave (
        output ins, data_resultRDY, data_exception,
        input  en_pc, en_writeReg, en_dmem_wr, sel_alu_dataB, sel_writeReg,
               ctrl_sw, ctrl_addi, is_alu, ctrl_Bne, ctrl_Blt, ctrl_ji, ctrl_jal, ctrl_jr,
               ctrl_MULT, ctrl_DIV, md_exc_wb, md_timeout_err, busy, retired_cnt
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> (MEM | MD_WAIT) -> WB with multdiv handshake.
// Define CTRL_MULTDIV_EN to build the MD_WAIT path; otherwise mult/div retire as NOPs.
module mc_control_unit #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input logic               clk,
    input logic               rst,
    mc_control_unit_if.master bus
);

    localparam logic [4:0] OpAlu   = 5'b00000;
    localparam logic [4:0] OpJ     = 5'b00001;
    localparam logic [4:0] OpBne   = 5'b00010;
    localparam logic [4:0] OpJal   = 5'b00011;
    localparam logic [4:0] OpJr    = 5'b00100;
    localparam logic [4:0] OpAddi  = 5'b00101;
    localparam logic [4:0] OpBlt   = 5'b00110;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] OpLw    = 5'b01000;
    localparam logic [4:0] AluMult = 5'b00110;
    localparam logic [4:0] AluDiv  = 5'b00111;

`ifdef CTRL_MULTDIV_EN
    localparam bit MdEn = 1'b1;
    localparam int unsigned TimerW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(MD_TIMEOUT - 1);
`else
    localparam bit MdEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
`ifdef CTRL_MULTDIV_EN
        StMdWait,
`endif
        StWb
    } state_e;

    typedef struct packed {
        logic alu;
        logic addi;
        logic sw;
        logic lw;
        logic bne;
        logic blt;
        logic ji;
        logic jal;
        logic jr;
        logic imm;
    } flags_t;

    // Without the multdiv path, mult/div are plain NOPs and raise no flags at all.
    function automatic flags_t decode_flags(input logic [4:0] op, input logic [4:0] aluop);
        flags_t f;
        logic   md;
        md     = (aluop == AluMult) || (aluop == AluDiv);
        f      = '0;
        f.alu  = (op == OpAlu) && (MdEn || !md);
        f.addi = (op == OpAddi);
        f.sw   = (op == OpSw);
        f.lw   = (op == OpLw);
        f.bne  = (op == OpBne);
        f.blt  = (op == OpBlt);
        f.ji   = (op == OpJ);
        f.jal  = (op == OpJal);
        f.jr   = (op == OpJr);
        f.imm  = (op == OpAddi) || (op == OpSw) || (op == OpLw);
        return f;
    endfunction

    state_e            state_q, state_d;
    flags_t            flags_q;
    logic [DWIDTH-1:0] ir_q;
    logic [CNT_W-1:0]  retired_q;
    logic [4:0]        op, aluop;
    logic              is_md;
    logic              en_pc, en_write, en_dmem, start_mult, start_div;
    logic              unused_ir;

`ifdef CTRL_MULTDIV_EN
    logic [TimerW-1:0] timer_q, timer_d;
    logic              md_exc_q, md_exc_d;
    logic              to_err_q, to_err_d;
`endif

    assign op        = ir_q[31:27];
    assign aluop     = ir_q[6:2];
    assign is_md     = (op == OpAlu) && ((aluop == AluMult) || (aluop == AluDiv));
    assign unused_ir = ^{ir_q[26:7], ir_q[1:0]};

    always_comb begin
        state_d    = state_q;
        en_pc      = 1'b0;
        en_write   = 1'b0;
        en_dmem    = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
`ifdef CTRL_MULTDIV_EN
        timer_d    = timer_q;
        md_exc_d   = md_exc_q;
        to_err_d   = to_err_q;
`endif
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                if ((op == OpLw) || (op == OpSw)) begin
                    state_d = StMem;
                end else if (((op == OpAlu) && !is_md) || (op == OpAddi) || (op == OpJal)) begin
                    state_d = StWb;
`ifdef CTRL_MULTDIV_EN
                end else if (is_md) begin
                    start_mult = (aluop == AluMult);
                    start_div  = (aluop == AluDiv);
                    timer_d    = '0;
                    state_d    = StMdWait;
`endif
                end else begin
                    // Branches, jumps and unknown opcodes retire straight from EXEC.
                    en_pc   = 1'b1;
                    state_d = StFetch;
                end
            end
            StMem: begin
                if (op == OpSw) begin
                    en_dmem = 1'b1;
                    en_pc   = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
`ifdef CTRL_MULTDIV_EN
            StMdWait: begin
                // Ready takes priority over a timeout landing in the same cycle.
                if (bus.data_resultRDY) begin
                    md_exc_d = bus.data_exception;
                    state_d  = StWb;
                end else if (timer_q == TimerLast) begin
                    to_err_d = 1'b1;
                    en_pc    = 1'b1;
                    state_d  = StFetch;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
`endif
            StWb: begin
                en_write = 1'b1;
                en_pc    = 1'b1;
                state_d  = StFetch;
`ifdef CTRL_MULTDIV_EN
                md_exc_d = 1'b0;
`endif
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            flags_q   <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                ir_q    <= bus.ins;
                flags_q <= decode_flags(bus.ins[31:27], bus.ins[6:2]);
            end else if (state_d == StFetch) begin
                flags_q <= '0;
            end
            if (en_pc) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

`ifdef CTRL_MULTDIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q  <= '0;
            md_exc_q <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            md_exc_q <= md_exc_d;
            to_err_q <= to_err_d;
        end
    end

    assign bus.md_exc_wb      = md_exc_q;
    assign bus.md_timeout_err = to_err_q;
`else
    logic unused_md;
    assign unused_md          = bus.data_resultRDY ^ bus.data_exception;
    assign bus.md_exc_wb      = 1'b0;
    assign bus.md_timeout_err = 1'b0;
`endif

    assign bus.en_pc         = en_pc;
    assign bus.en_writeReg   = en_write;
    assign bus.en_dmem_wr    = en_dmem;
    assign bus.ctrl_MULT     = start_mult;
    assign bus.ctrl_DIV      = start_div;
    assign bus.sel_alu_dataB = flags_q.imm;
    assign bus.sel_writeReg  = flags_q.lw && ((state_q == StMem) || (state_q == StWb));
    assign bus.ctrl_sw       = flags_q.sw;
    assign bus.ctrl_addi     = flags_q.addi;
    assign bus.is_alu        = flags_q.alu;
    assign bus.ctrl_Bne      = flags_q.bne;
    assign bus.ctrl_Blt      = flags_q.blt;
    assign bus.ctrl_ji       = flags_q.ji;
    assign bus.ctrl_jal      = flags_q.jal;
    assign bus.ctrl_jr       = flags_q.jr;
    assign bus.busy          = (state_q != StFetch);
    assign bus.retired_cnt   = retired_q;

endmodule
